// File: rtl/aes_pkg.sv
// Shared AES constants and the S-box arbiter FSM state encoding.
//   BYTE_W   : width of one state/word byte
//   ST_BYTES : bytes in a 128-bit AES state (SubBytes job length)
//   KW_BYTES : bytes in a 32-bit key-expansion word (SubWord job length)
//   ROM_LAT  : S-box ROM read latency in cycles
package aes_pkg;

  localparam int BYTE_W   = 8;
  localparam int ST_BYTES = 16;
  localparam int KW_BYTES = 4;
  localparam int ROM_LAT  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Byte k of a 128-bit vector (byte k = bits [8k+7:8k]).
  function automatic logic [BYTE_W-1:0] get_byte(input logic [ST_BYTES*BYTE_W-1:0] v,
                                                 input logic [3:0] k);
    return v[{k, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/sbox_arbiter.sv
// Shares one external synchronous S-box ROM between a SubBytes requester
// (128-bit state, 16 lookups) and a SubWord requester (32-bit word, 4 lookups).
// One job owns the ROM from grant to completion; no preemption.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   st_req/st_in       : SubBytes level request and state operand
//   st_out/st_done     : registered substituted state, one-cycle done pulse
//   kw_req/kw_in       : SubWord level request and word operand
//   kw_out/kw_done     : registered substituted word, one-cycle done pulse
//   busy               : high whenever the FSM is not idle
//   rom_rd/rom_addr    : ROM read strobe and byte address
//   rom_data           : ROM output, valid the cycle after rom_rd
module sbox_arbiter
  import aes_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_req,
  input  logic [ST_BYTES*BYTE_W-1:0]   st_in,
  output logic [ST_BYTES*BYTE_W-1:0]   st_out,
  output logic                         st_done,
  input  logic                         kw_req,
  input  logic [KW_BYTES*BYTE_W-1:0]   kw_in,
  output logic [KW_BYTES*BYTE_W-1:0]   kw_out,
  output logic                         kw_done,
  output logic                         busy,
  output logic                         rom_rd,
  output logic [BYTE_W-1:0]            rom_addr,
  input  logic [BYTE_W-1:0]            rom_data
);

  state_t                       state_reg;
  logic [ST_BYTES*BYTE_W-1:0]   op_reg;      // operand latched at grant
  logic [ST_BYTES*BYTE_W-1:0]   work_reg;    // partially substituted result
  logic [4:0]                   n_reg;       // byte count of the granted job
  logic [4:0]                   idx_reg;     // byte presented to the ROM this cycle
  logic                         gnt_kw_reg;  // current job belongs to KW
  logic                         last_kw_reg; // last grant went to KW

  logic                         pick_kw;
  logic [3:0]                   wr_sel;
  logic [ST_BYTES*BYTE_W-1:0]   work_merged;

  // KW has priority on a tie unless it was served last time.
  assign pick_kw = kw_req && (!st_req || !last_kw_reg);

  // rom_data returning now belongs to the byte issued ROM_LAT cycles ago.
  assign wr_sel = idx_reg[3:0] - 4'(ROM_LAT);

  always_comb begin
    work_merged = work_reg;
    work_merged[{wr_sel, 3'b000} +: BYTE_W] = rom_data;
  end

  assign busy = (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      work_reg    <= '0;
      n_reg       <= '0;
      idx_reg     <= '0;
      gnt_kw_reg  <= 1'b0;
      last_kw_reg <= 1'b0;
      st_out      <= '0;
      kw_out      <= '0;
      st_done     <= 1'b0;
      kw_done     <= 1'b0;
      rom_rd      <= 1'b0;
      rom_addr    <= '0;
    end else begin
      st_done <= 1'b0;
      kw_done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (st_req || kw_req) begin
            gnt_kw_reg  <= pick_kw;
            last_kw_reg <= pick_kw;
            op_reg      <= pick_kw ? {96'h0, kw_in} : st_in;
            n_reg       <= pick_kw ? 5'(KW_BYTES) : 5'(ST_BYTES);
            idx_reg     <= '0;
            work_reg    <= '0;
            rom_rd      <= 1'b1;
            rom_addr    <= pick_kw ? kw_in[BYTE_W-1:0] : st_in[BYTE_W-1:0];
            state_reg   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The first ISSUE cycle has no ROM data in flight yet.
          if (idx_reg != 5'd0) begin
            work_reg <= work_merged;
          end
          idx_reg <= idx_reg + 5'd1;
          if (idx_reg == n_reg - 5'd1) begin
            rom_rd    <= 1'b0;
            state_reg <= S_DRAIN;
          end else begin
            rom_addr <= get_byte(op_reg, idx_reg[3:0] + 4'd1);
          end
        end
        S_DRAIN: begin
          // Last byte arrives now; fold it straight into the output register
          // so the result and done pulse are visible together in DONE.
          if (gnt_kw_reg) begin
            kw_out  <= work_merged[KW_BYTES*BYTE_W-1:0];
            kw_done <= 1'b1;
          end else begin
            st_out  <= work_merged;
            st_done <= 1'b1;
          end
          state_reg <= S_DONE;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_arbiter.sv
module tb_sbox_arbiter;

  logic         clk;
  logic         rst_n;
  logic         st_req;
  logic [127:0] st_in;
  logic [127:0] st_out;
  logic         st_done;
  logic         kw_req;
  logic [31:0]  kw_in;
  logic [31:0]  kw_out;
  logic         kw_done;
  logic         busy;
  logic         rom_rd;
  logic [7:0]   rom_addr;
  logic [7:0]   rom_data;

  int total = 0;
  int bad   = 0;

  sbox_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_req   (st_req),
    .st_in    (st_in),
    .st_out   (st_out),
    .st_done  (st_done),
    .kw_req   (kw_req),
    .kw_in    (kw_in),
    .kw_out   (kw_out),
    .kw_done  (kw_done),
    .busy     (busy),
    .rom_rd   (rom_rd),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AES S-box, one row per high nibble, column 0 in the top byte.
  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [127:0] row;
    row = sbox_rows[a[7:4]];
    return row[8*(15-int'(a[3:0])) +: 8];
  endfunction

  // External synchronous ROM: one cycle read latency.
  initial rom_data = 8'h00;
  always @(posedge clk) begin
    if (rom_rd) rom_data <= sbox_f(rom_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Runs one single-requester job; returns done latency (-1 on timeout),
  // number of rom_rd cycles, and whether addresses walked the operand bytes.
  task automatic run_job(input bit is_kw, input logic [127:0] din,
                         output int lat, output int rds, output bit addr_ok);
    lat = -1; rds = 0; addr_ok = 1'b1;
    if (is_kw) begin kw_in = din[31:0]; kw_req = 1'b1; end
    else       begin st_in = din;       st_req = 1'b1; end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (rom_rd) begin
        if (rom_addr !== din[8*rds +: 8]) addr_ok = 1'b0;
        rds++;
      end
      if ((is_kw && kw_done) || (!is_kw && st_done)) begin
        lat = k;
        st_req = 1'b0;
        kw_req = 1'b0;
        break;
      end
    end
    st_req = 1'b0;
    kw_req = 1'b0;
  endtask

  typedef struct {
    bit           is_kw;
    logic [127:0] din;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs [6];

  logic [127:0] exp_st;
  logic [31:0]  exp_kw;
  int           lat, rds;
  bit           addr_ok;
  int           kw1, st_t, kw2;
  logic [127:0] st_val;
  logic [31:0]  kw_val;
  bit           seen_done;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 128'h0, {16{8'h63}}, 18};
    vecs[1] = '{1'b1, 128'h000053ff, 128'h6363ed16, 6};
    vecs[2] = '{1'b1, 128'h00010203, 128'h637c777b, 6};
    vecs[3] = '{1'b0, 128'h0f0e0d0c0b0a09080706050403020100,
                      128'h76abd7fe2b670130c56f6bf27b777c63, 18};
    vecs[4] = '{1'b0, {16{8'hff}}, {16{8'h16}}, 18};
    vecs[5] = '{1'b1, 128'hffffffff, 128'h16161616, 6};

    rst_n = 1'b0; st_req = 1'b0; kw_req = 1'b0; st_in = '0; kw_in = '0;
    tick(); tick(); tick();
    chk("rst_busy",    128'(busy),     128'(0));
    chk("rst_rom_rd",  128'(rom_rd),   128'(0));
    chk("rst_addr",    128'(rom_addr), 128'(0));
    chk("rst_st_out",  st_out,         128'(0));
    chk("rst_kw_out",  128'(kw_out),   128'(0));
    chk("rst_dones",   128'({st_done, kw_done}), 128'(0));
    rst_n = 1'b1;
    tick();
    exp_st = '0; exp_kw = '0;

    // Simultaneous requests, both held: KW, then ST, then the repeat KW.
    st_in = '0; kw_in = 32'h000053ff; st_req = 1'b1; kw_req = 1'b1;
    kw1 = -1; st_t = -1; kw2 = -1; st_val = '0; kw_val = '0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (kw_done) begin
        if (kw1 < 0) begin kw1 = k; kw_val = kw_out; end
        else begin kw2 = k; kw_req = 1'b0; end
      end
      if (st_done) begin st_t = k; st_val = st_out; st_req = 1'b0; end
      if (kw2 > 0) break;
    end
    st_req = 1'b0; kw_req = 1'b0;
    chk("arb_kw_first_cycle", 128'(kw1), 128'(6));
    chk("arb_kw_first_val",   128'(kw_val), 128'h6363ed16);
    chk("arb_st_cycle",       128'(st_t), 128'(25));
    chk("arb_st_val",         st_val, {16{8'h63}});
    chk("arb_kw_repeat_cycle", 128'(kw2), 128'(32));
    exp_st = {16{8'h63}}; exp_kw = 32'h6363ed16;
    tick();
    chk("arb_idle_after", 128'(busy), 128'(0));

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].is_kw, vecs[i].din, lat, rds, addr_ok);
      chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
      chk($sformatf("v%0d_rom_rds", i), 128'(rds), 128'(vecs[i].is_kw ? 4 : 16));
      chk($sformatf("v%0d_addrs", i),   128'(addr_ok), 128'(1));
      if (vecs[i].is_kw) begin
        exp_kw = vecs[i].exp[31:0];
        chk($sformatf("v%0d_kw_out", i), 128'(kw_out), 128'(exp_kw));
        chk($sformatf("v%0d_st_hold", i), st_out, exp_st);
      end else begin
        exp_st = vecs[i].exp;
        chk($sformatf("v%0d_st_out", i), st_out, exp_st);
        chk($sformatf("v%0d_kw_hold", i), 128'(kw_out), 128'(exp_kw));
      end
      tick();
      chk($sformatf("v%0d_idle", i), 128'({busy, rom_rd, st_done, kw_done}), 128'(0));
    end

    // Operand changes mid-job must not disturb the running job.
    st_in = 128'h0f0e0d0c0b0a09080706050403020100; st_req = 1'b1;
    tick(); tick(); tick();
    st_in = {16{8'h55}};
    lat = -1;
    for (int k = 4; k <= 40; k++) begin
      tick();
      if (st_done) begin lat = k; st_req = 1'b0; break; end
    end
    st_req = 1'b0;
    chk("chg_latency", 128'(lat), 128'(18));
    chk("chg_st_out",  st_out, 128'h76abd7fe2b670130c56f6bf27b777c63);
    tick();

    // Reset during ISSUE cycle 5 of an ST job.
    st_in = {16{8'hff}}; st_req = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("mid_busy_before_rst", 128'(busy), 128'(1));
    rst_n = 1'b0; st_req = 1'b0;
    #1;
    chk("mid_rst_st_out", st_out, 128'(0));
    chk("mid_rst_kw_out", 128'(kw_out), 128'(0));
    chk("mid_rst_ctl",    128'({busy, rom_rd, rom_addr}), 128'(0));
    seen_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (st_done || busy) seen_done = 1'b1;
    end
    chk("mid_no_resume", 128'(seen_done), 128'(0));
    run_job(1'b1, 128'h000053ff, lat, rds, addr_ok);
    chk("post_rst_kw_latency", 128'(lat), 128'(6));
    chk("post_rst_kw_out",     128'(kw_out), 128'h6363ed16);
    chk("post_rst_st_out",     st_out, 128'(0));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
